// File: rtl/uart_rx_if.sv
// Serial receive bundle: raw line and enable in, received byte and
// one-cycle status pulses out.
// master: the receiver (samples uart_rxd/uart_rx_en, drives results).
// slave:  the line driver / consumer of received data.
interface uart_rx_if #(
  parameter int PAYLOAD_BITS = 8
);
  logic                    uart_rxd;
  logic                    uart_rx_en;
  logic                    uart_rx_valid;
  logic [PAYLOAD_BITS-1:0] uart_rx_data;
  logic                    uart_rx_frame_err;
  logic                    uart_rx_break;

  modport master (
    input  uart_rxd,
    input  uart_rx_en,
    output uart_rx_valid,
    output uart_rx_data,
    output uart_rx_frame_err,
    output uart_rx_break
  );

  modport slave (
    output uart_rxd,
    output uart_rx_en,
    input  uart_rx_valid,
    input  uart_rx_data,
    input  uart_rx_frame_err,
    input  uart_rx_break
  );
endinterface

// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronised line, mid-bit sampling, LSB first, one stop bit.
// Latency: status pulse 1 cycle after the stop-bit sample (~2+HALF_BIT+(PAYLOAD_BITS+1)*CYCLES_PER_BIT+1 from pin edge).
// Backpressure: none; a pulse is emitted once per frame and uart_rx_data holds until the next good frame.
// Ports: clk (rising edge), reset (synchronous, active high),
//        rx (uart_rx_if.master): uart_rxd/uart_rx_en in; uart_rx_valid, uart_rx_data,
//        uart_rx_frame_err, uart_rx_break out.
module uart_rx #(
  parameter int CLK_HZ       = 50000000,
  parameter int BIT_RATE     = 9600,
  parameter int PAYLOAD_BITS = 8
) (
  input  logic      clk,
  input  logic      reset,
  uart_rx_if.master rx
);

  localparam int CYCLES_PER_BIT = CLK_HZ / BIT_RATE;
  localparam int HALF_BIT       = CYCLES_PER_BIT / 2;
  localparam int CNT_W          = $clog2(CYCLES_PER_BIT + 1);
  localparam int IDX_W          = $clog2(PAYLOAD_BITS + 1);

  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CYCLES_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PAYLOAD_BITS - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    RECV,
    STOP
  } state_t;

  state_t                  state;
  logic [CNT_W-1:0]        cnt;
  logic [IDX_W-1:0]        idx;
  logic [PAYLOAD_BITS-1:0] shreg;

  // rxd_m is the metastability flop; rxd_s is the usable value and
  // rxd_p its one-cycle-old copy for edge detection. All reset to idle-high
  // so a reset never looks like a falling edge by itself.
  logic rxd_m;
  logic rxd_s;
  logic rxd_p;

  always_ff @(posedge clk) begin
    if (reset) begin
      rxd_m <= 1'b1;
      rxd_s <= 1'b1;
      rxd_p <= 1'b1;
    end else begin
      rxd_m <= rx.uart_rxd;
      rxd_s <= rxd_m;
      rxd_p <= rxd_s;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state                <= IDLE;
      cnt                  <= '0;
      idx                  <= '0;
      shreg                <= '0;
      rx.uart_rx_data      <= '0;
      rx.uart_rx_valid     <= 1'b0;
      rx.uart_rx_frame_err <= 1'b0;
      rx.uart_rx_break     <= 1'b0;
    end else begin
      // Status outputs are single-cycle pulses.
      rx.uart_rx_valid     <= 1'b0;
      rx.uart_rx_frame_err <= 1'b0;
      rx.uart_rx_break     <= 1'b0;

      if (state != IDLE && !rx.uart_rx_en) begin
        // Enable dropped mid-frame: abandon silently.
        state <= IDLE;
        cnt   <= '0;
        idx   <= '0;
      end else begin
        case (state)
          IDLE: begin
            cnt <= '0;
            idx <= '0;
            // Only a genuine high-to-low transition starts a frame, so a
            // line stuck low after a break cannot retrigger.
            if (rx.uart_rx_en && rxd_p && !rxd_s) begin
              state <= START;
            end
          end

          START: begin
            if (cnt == CNT_HALF) begin
              cnt <= '0;
              idx <= '0;
              // Re-check at mid start bit to reject short glitches.
              state <= rxd_s ? IDLE : RECV;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end

          RECV: begin
            if (cnt == CNT_FULL) begin
              cnt <= '0;
              // Shift right so the first (LSB) bit ends up in bit 0.
              if (PAYLOAD_BITS > 1) begin
                shreg <= {rxd_s, shreg[PAYLOAD_BITS-1:1]};
              end else begin
                shreg <= PAYLOAD_BITS'(rxd_s);
              end
              if (idx == IDX_LAST) begin
                idx   <= '0;
                state <= STOP;
              end else begin
                idx <= idx + 1'b1;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end

          STOP: begin
            if (cnt == CNT_FULL) begin
              cnt   <= '0;
              state <= IDLE;
              if (rxd_s) begin
                rx.uart_rx_valid <= 1'b1;
                rx.uart_rx_data  <= shreg;
              end else if (shreg == '0) begin
                rx.uart_rx_break <= 1'b1;
              end else begin
                rx.uart_rx_frame_err <= 1'b1;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end

          default: begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit.
// Drives whole and partial frames on the line and counts the status pulses.
// Ports: none (top-level bench).
module tb_uart_rx;

  localparam int CLK_HZ   = 16;
  localparam int BIT_RATE = 1;
  localparam int PB       = 8;
  localparam int CPB      = 16;
  // 2 sync + HALF_BIT + 9 bit periods + 1 output register
  localparam int EXP_LAT  = 2 + CPB / 2 + (PB + 1) * CPB + 1;

  logic clk = 1'b0;
  logic reset;

  uart_rx_if #(.PAYLOAD_BITS(PB)) rx_bus ();

  uart_rx #(
    .CLK_HZ      (CLK_HZ),
    .BIT_RATE    (BIT_RATE),
    .PAYLOAD_BITS(PB)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .rx   (rx_bus.master)
  );

  always #5 clk = ~clk;

  int vec_cnt = 0;
  int err_cnt = 0;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor: counts high cycles, so a stretched pulse shows up as
  // an extra count.
  int          n_valid = 0;
  int          n_ferr  = 0;
  int          n_brk   = 0;
  int          multi_hot = 0;
  int          last_valid_cyc = 0;
  logic [PB-1:0] data_log[$];

  always @(negedge clk) begin
    if (reset === 1'b0) begin
      if (rx_bus.uart_rx_valid === 1'b1) begin
        n_valid        <= n_valid + 1;
        last_valid_cyc <= cyc;
        data_log.push_back(rx_bus.uart_rx_data);
      end
      if (rx_bus.uart_rx_frame_err === 1'b1) n_ferr <= n_ferr + 1;
      if (rx_bus.uart_rx_break === 1'b1)     n_brk  <= n_brk + 1;
      if ((int'(rx_bus.uart_rx_valid === 1'b1) + int'(rx_bus.uart_rx_frame_err === 1'b1)
           + int'(rx_bus.uart_rx_break === 1'b1)) > 1)
        multi_hot <= multi_hot + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  int base_v = 0;
  int base_f = 0;
  int base_b = 0;
  int fall_cyc = 0;

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Compare pulse counts since the previous call, then rebase.
  task automatic expect_pulses(input string tag, input int v, input int f, input int b);
    chk({tag, "_valid"}, 32'(n_valid - base_v), 32'(v));
    chk({tag, "_ferr"},  32'(n_ferr - base_f),  32'(f));
    chk({tag, "_brk"},   32'(n_brk - base_b),   32'(b));
    base_v = n_valid;
    base_f = n_ferr;
    base_b = n_brk;
  endtask

  task automatic send_frame(input logic [PB-1:0] d, input logic stop);
    rx_bus.uart_rxd = 1'b0;
    fall_cyc = cyc;
    wait_cyc(CPB);
    for (int i = 0; i < PB; i++) begin
      rx_bus.uart_rxd = d[i];
      wait_cyc(CPB);
    end
    rx_bus.uart_rxd = stop;
    wait_cyc(CPB);
    rx_bus.uart_rxd = 1'b1;
  endtask

  // Start bit, nbits full data bits, then half of data bit nbits.
  task automatic send_partial(input logic [PB-1:0] d, input int nbits);
    rx_bus.uart_rxd = 1'b0;
    wait_cyc(CPB);
    for (int i = 0; i < nbits; i++) begin
      rx_bus.uart_rxd = d[i];
      wait_cyc(CPB);
    end
    rx_bus.uart_rxd = d[nbits];
    wait_cyc(CPB / 2);
  endtask

  initial begin
    reset             = 1'b1;
    rx_bus.uart_rxd   = 1'b1;
    rx_bus.uart_rx_en = 1'b1;
    wait_cyc(3);
    @(negedge clk);
    chk("rst_valid", 32'(rx_bus.uart_rx_valid), 32'h0);
    chk("rst_ferr",  32'(rx_bus.uart_rx_frame_err), 32'h0);
    chk("rst_brk",   32'(rx_bus.uart_rx_break), 32'h0);
    chk("rst_data",  32'(rx_bus.uart_rx_data), 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    wait_cyc(20);

    // Single good frame, with end-to-end latency.
    send_frame(8'hA5, 1'b1);
    wait_cyc(5);
    expect_pulses("a5", 1, 0, 0);
    chk("a5_data", 32'(rx_bus.uart_rx_data), 32'hA5);
    chk("a5_latency_in_window",
        32'((last_valid_cyc - fall_cyc >= EXP_LAT - 1) && (last_valid_cyc - fall_cyc <= EXP_LAT + 1)),
        32'h1);

    // Back-to-back frames with no idle gap.
    data_log.delete();
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    wait_cyc(5);
    expect_pulses("b2b", 2, 0, 0);
    chk("b2b_count", 32'(data_log.size()), 32'd2);
    if (data_log.size() == 2) begin
      chk("b2b_data0", 32'(data_log[0]), 32'h00);
      chk("b2b_data1", 32'(data_log[1]), 32'hFF);
    end

    // Stop bit low with nonzero payload: framing error, data held.
    send_frame(8'h3C, 1'b0);
    wait_cyc(20);
    expect_pulses("ferr", 0, 1, 0);
    chk("ferr_data_held", 32'(rx_bus.uart_rx_data), 32'hFF);

    // Line held low for 40 bit periods: one break, no retrigger.
    rx_bus.uart_rxd = 1'b0;
    wait_cyc(40 * CPB);
    rx_bus.uart_rxd = 1'b1;
    wait_cyc(100);
    expect_pulses("brk", 0, 0, 1);
    chk("brk_data_held", 32'(rx_bus.uart_rx_data), 32'hFF);

    // Short low glitch: false start.
    rx_bus.uart_rxd = 1'b0;
    wait_cyc(4);
    rx_bus.uart_rxd = 1'b1;
    wait_cyc(300);
    expect_pulses("glitch", 0, 0, 0);

    // Reset in the middle of bit 3.
    send_partial(8'h81, 3);
    reset = 1'b1;
    wait_cyc(3);
    rx_bus.uart_rxd = 1'b1;
    reset = 1'b0;
    wait_cyc(300);
    expect_pulses("rst_abort", 0, 0, 0);
    chk("rst_abort_data", 32'(rx_bus.uart_rx_data), 32'h0);

    // Enable dropped in the middle of bit 3.
    send_partial(8'h81, 3);
    rx_bus.uart_rx_en = 1'b0;
    wait_cyc(2);
    rx_bus.uart_rxd = 1'b1;
    wait_cyc(2);
    rx_bus.uart_rx_en = 1'b1;
    wait_cyc(300);
    expect_pulses("en_abort", 0, 0, 0);

    // Whole frame while disabled is ignored.
    rx_bus.uart_rx_en = 1'b0;
    send_frame(8'h55, 1'b1);
    wait_cyc(20);
    rx_bus.uart_rx_en = 1'b1;
    wait_cyc(20);
    expect_pulses("disabled", 0, 0, 0);
    chk("disabled_data", 32'(rx_bus.uart_rx_data), 32'h0);

    // Clean frame after the aborts.
    send_frame(8'h81, 1'b1);
    wait_cyc(5);
    expect_pulses("x81", 1, 0, 0);
    chk("x81_data", 32'(rx_bus.uart_rx_data), 32'h81);

    chk("one_hot_status", 32'(multi_hot), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50000000: system clock frequency in Hz.
REQ-002 SHALL have parameter BIT_RATE, default 9600: serial bit rate in bits/s.
REQ-003 SHALL have parameter PAYLOAD_BITS, default 8: data bits per frame.
REQ-004 SHALL derive local constant CYCLES_PER_BIT = CLK_HZ/BIT_RATE (integer divide) and HALF_BIT = CYCLES_PER_BIT/2.
REQ-005 SHALL have port clk  input  1: the single clock; all logic on rising edge.
REQ-006 SHALL have port reset  input  1: synchronous, active-high reset.
REQ-007 SHALL have port uart_rxd  input  1: asynchronous serial line, idle high.
REQ-008 SHALL have port uart_rx_en  input  1: receive enable.
REQ-009 SHALL have port uart_rx_valid  output  1: one-cycle pulse, a good frame was received.
REQ-010 SHALL have port uart_rx_data  output  PAYLOAD_BITS: last good received byte.
REQ-011 SHALL have port uart_rx_frame_err  output  1: one-cycle pulse, stop bit sampled low.
REQ-012 SHALL have port uart_rx_break  output  1: one-cycle pulse, all-zero payload with low stop bit.

Function
REQ-013 SHALL pass uart_rxd through a 2-flop synchroniser reset to 1; all decisions use the synchronised value (rxd_s) and its previous value (rxd_p).
REQ-014 SHALL implement FSM states IDLE, START, RECV, STOP.
REQ-015 IDLE: on falling edge (rxd_p=1, rxd_s=0) with uart_rx_en=1 -> START, bit-cycle counter cleared.
REQ-016 START: at counter = HALF_BIT-1, sample rxd_s; 0 -> RECV (counter cleared, bit index 0); 1 -> IDLE (false start, no output pulse).
REQ-017 RECV: sample rxd_s at counter = CYCLES_PER_BIT-1, store into data shift register LSB first, clear counter, increment bit index; after PAYLOAD_BITS samples -> STOP.
REQ-018 STOP: sample rxd_s at counter = CYCLES_PER_BIT-1, then -> IDLE.
- stop=1: uart_rx_valid=1 next cycle; uart_rx_data updated that same cycle.
- stop=0, payload nonzero: uart_rx_frame_err=1 next cycle; uart_rx_data unchanged.
- stop=0, payload all zero: uart_rx_break=1 next cycle (frame_err stays 0); uart_rx_data unchanged.
REQ-019 At most one of valid, frame_err, break SHALL be high in any cycle; each SHALL be high for exactly one cycle per frame.
REQ-020 uart_rx_data SHALL hold its value between good frames.
REQ-021 After STOP, a new start SHALL be detected only after a falling edge; a line held low (break) SHALL NOT retrigger reception.
REQ-022 uart_rx_en deasserted in any non-IDLE state SHALL abort to IDLE on the next cycle with no output pulse; while low, IDLE SHALL ignore the line.
REQ-023 Counter width SHALL be $clog2(CYCLES_PER_BIT+1); counter SHALL never wrap within a bit period.
REQ-024 Latency: pulse appears 1 cycle after the stop-bit sample, i.e. 2 (sync) + HALF_BIT + (PAYLOAD_BITS+1)*CYCLES_PER_BIT + 1 cycles after the start-bit falling edge at the pin (±1 cycle edge alignment).

Reset
REQ-025 reset=1 at a rising edge SHALL force: state IDLE, counter 0, bit index 0, synchroniser 1s, uart_rx_data 0, valid/frame_err/break 0.
REQ-026 reset asserted mid-frame SHALL discard the partial frame; no pulse SHALL be emitted for it after reset release.

Verification (CLK_HZ=16, BIT_RATE=1 -> CYCLES_PER_BIT=16)
REQ-027 Frame 0xA5, stop=1, en=1 -> single valid pulse, uart_rx_data=0xA5, no frame_err/break.
REQ-028 Back-to-back 0x00 then 0xFF, no idle gap -> two valid pulses, data 0x00 then 0xFF.
REQ-029 Frame 0x3C with stop bit low -> one frame_err pulse, uart_rx_data keeps previous value.
REQ-030 Line low for 40 bit periods -> exactly one break pulse, no further activity until line high then next falling edge.
REQ-031 Low glitch of 4 cycles on idle line -> false start, returns to IDLE, no pulse.
REQ-032 reset (or uart_rx_en=0) asserted during bit 3 of 0x81 -> no pulse; subsequent clean 0x81 frame -> valid, data=0x81.
